// File: rtl/laoc_mem_pkg.sv
// laoc_mem_pkg -- shared definitions for the memory issue queue.
//   Instruction (43 bits): [42:40] tag, [39] mem-op, [38] store(1)/load(0),
//     [37:36] unused, [35:32] dest reg, [31:16] store addr,
//     [15:0] store data / load addr.
//   Solution (23 bits): [22:19] reg, [18:16] tag, [15:0] data.
//   Also holds the issue FSM state enum.
package laoc_mem_pkg;

  localparam int INSTR_W = 43;
  localparam int SOL_W   = 23;
  localparam int DATA_W  = 16;
  localparam int REG_W   = 4;
  localparam int TAG_W   = 3;

  // Instruction field positions
  localparam int I_TAG_HI   = 42;
  localparam int I_TAG_LO   = 40;
  localparam int I_MEMOP    = 39;
  localparam int I_STORE    = 38;
  localparam int I_DEST_HI  = 35;
  localparam int I_DEST_LO  = 32;
  localparam int I_SADDR_HI = 31;
  localparam int I_SADDR_LO = 16;
  localparam int I_DATA_HI  = 15;
  localparam int I_DATA_LO  = 0;

  // Solution field positions
  localparam int S_REG_HI  = 22;
  localparam int S_REG_LO  = 19;
  localparam int S_TAG_HI  = 18;
  localparam int S_TAG_LO  = 16;
  localparam int S_DATA_HI = 15;
  localparam int S_DATA_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT      = 2'd2,
    ST_WRITEBACK = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo -- synchronous request FIFO, DEPTH entries (power of two).
//   clock, reset_n : clock, asynchronous active-low reset (empties FIFO)
//   push, wr_data  : write one entry (caller guarantees !full)
//   pop            : remove head entry (caller guarantees !empty)
//   rd_data        : current head entry (valid while !empty)
//   full, empty    : occupancy flags
// Push and pop in the same cycle are allowed; pointers wrap modulo DEPTH.
module mem_req_fifo
  import laoc_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = INSTR_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two DEPTH lets the pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_issue_queue.sv
// mem_issue_queue -- queues memory instructions, issues them one at a time
// to the memory unit and broadcasts each result on the common data bus.
//   clock, reset_n     : clock, asynchronous active-low reset
//   in_valid/in_instr  : producer side (in_ready = FIFO not full)
//   mem_key, mem_instr : one-cycle request strobe + held instruction
//   mem_done/mem_solution : memory completion pulse + result
//   cdb_valid/cdb_ack, cdb_reg/tag/data/store : result broadcast
//   busy               : FSM not idle or FIFO non-empty
//   state_dbg          : current FSM state
//   timeout_err        : sticky WAIT timeout flag (MEM_TIMEOUT_EN only)
// Optional feature macro: MEM_TIMEOUT_EN -- re-issue the request when WAIT
// lasts TIMEOUT cycles without mem_done.
//
// Handshakes: a transfer happens on a rising edge where valid and
// ready/ack are both high; the offering side holds valid and payload
// stable until then. Instructions without the mem-op bit are accepted and
// dropped.
module mem_issue_queue
  import laoc_mem_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               mem_key,
  output logic [INSTR_W-1:0] mem_instr,
  input  logic               mem_done,
  input  logic [SOL_W-1:0]   mem_solution,
  output logic               cdb_valid,
  output logic [REG_W-1:0]   cdb_reg,
  output logic [TAG_W-1:0]   cdb_tag,
  output logic [DATA_W-1:0]  cdb_data,
  output logic               cdb_store,
  input  logic               cdb_ack,
  output logic               busy,
`ifdef MEM_TIMEOUT_EN
  output logic               timeout_err,
`endif
  output logic [1:0]         state_dbg
);

  mem_state_e state, state_nx;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] fifo_head;
  logic               done_in_wait;

  assign in_ready     = !fifo_full;
  assign fifo_push    = in_valid && in_ready && in_instr[I_MEMOP];
  assign done_in_wait = (state == ST_WAIT) && mem_done;

  mem_req_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wr_data (in_instr),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          wait_expired;

  // wait_cnt counts completed WAIT cycles; the TIMEOUT-th WAIT cycle
  // without mem_done sends the FSM back to ISSUE.
  assign wait_expired = (state == ST_WAIT) && !mem_done &&
                        (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_WAIT && !wait_expired) wait_cnt <= wait_cnt + TW'(1);
      else                                   wait_cnt <= '0;
      if (wait_expired) timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fifo_pop = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (mem_done) state_nx = ST_WRITEBACK;
`ifdef MEM_TIMEOUT_EN
        else if (wait_expired) state_nx = ST_ISSUE;
`endif
      end
      ST_WRITEBACK: begin
        if (cdb_ack) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign mem_key   = (state == ST_ISSUE);
  assign cdb_valid = (state == ST_WRITEBACK);
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign state_dbg = state;

  // mem_instr is loaded only on pop, so it stays stable through a re-issue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_instr <= '0;
      cdb_reg   <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_store <= 1'b0;
    end else begin
      if (fifo_pop) mem_instr <= fifo_head;
      if (done_in_wait) begin
        cdb_reg   <= mem_solution[S_REG_HI:S_REG_LO];
        cdb_tag   <= mem_solution[S_TAG_HI:S_TAG_LO];
        cdb_data  <= mem_solution[S_DATA_HI:S_DATA_LO];
        cdb_store <= mem_instr[I_STORE];
      end
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// tb_mem_issue_queue -- directed bench for mem_issue_queue with a small
// memory responder and a broadcast scoreboard. Define MEM_TIMEOUT_EN to
// include the timeout scenario.
module tb_mem_issue_queue;
  import laoc_mem_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 15;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset_n;
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic               mem_key;
  logic [INSTR_W-1:0] mem_instr;
  logic               mem_done = 1'b0;
  logic [SOL_W-1:0]   mem_solution = '0;
  logic               cdb_valid;
  logic [REG_W-1:0]   cdb_reg;
  logic [TAG_W-1:0]   cdb_tag;
  logic [DATA_W-1:0]  cdb_data;
  logic               cdb_store;
  logic               cdb_ack;
  logic               busy;
  logic [1:0]         state_dbg;
`ifdef MEM_TIMEOUT_EN
  logic               timeout_err;
`endif

  mem_issue_queue #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .mem_key      (mem_key),
    .mem_instr    (mem_instr),
    .mem_done     (mem_done),
    .mem_solution (mem_solution),
    .cdb_valid    (cdb_valid),
    .cdb_reg      (cdb_reg),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_store    (cdb_store),
    .cdb_ack      (cdb_ack),
    .busy         (busy),
`ifdef MEM_TIMEOUT_EN
    .timeout_err  (timeout_err),
`endif
    .state_dbg    (state_dbg)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [2:0] tag, input logic st,
                                            input logic [3:0] rg, input logic [15:0] sa,
                                            input logic [15:0] d);
    return {tag, 1'b1, st, 2'b00, rg, sa, d};
  endfunction

  function automatic logic [23:0] bc(input logic st, input logic [3:0] rg,
                                     input logic [2:0] tag, input logic [15:0] d);
    return {st, rg, tag, d};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [23:0] exp_q[$];
  int          key_cnt = 0;
  int          bc_cnt  = 0;
  logic        stall_prev = 1'b0;
  logic [23:0] prev_bc = '0;

  always @(negedge clock) begin
    logic [23:0] cur;
    cur = {cdb_store, cdb_reg, cdb_tag, cdb_data};
    if (mem_key) key_cnt++;
    if (cdb_valid) begin
      if (stall_prev) check("cdb_hold", cur, prev_bc);
      if (cdb_ack) begin
        bc_cnt++;
        check("bcast_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("bcast_fields", cur, exp_q.pop_front());
      end
      stall_prev = !cdb_ack;
      prev_bc    = cur;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- memory responder ----------------
  logic [15:0]        mem_arr [256];
  logic [INSTR_W-1:0] pend = '0;
  int                 pend_cnt = -1;
  logic               mem_mute = 1'b0;

  always @(negedge clock) begin
    logic [15:0] d;
    mem_done = 1'b0;
    if (pend_cnt == 0) begin
      if (pend[38]) begin
        mem_arr[pend[23:16]] = pend[15:0];
        d = pend[15:0];
      end else begin
        d = mem_arr[pend[7:0]];
      end
      mem_solution = {pend[35:32], pend[42:40], d};
      mem_done = 1'b1;
      pend_cnt = -1;
    end else if (pend_cnt > 0) begin
      pend_cnt--;
    end
    if (mem_key && !mem_mute) begin
      pend     = mem_instr;
      pend_cnt = 2;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [INSTR_W-1:0] x);
    int k;
    in_valid = 1'b1;
    in_instr = x;
    k = 0;
    while (!in_ready && k < 200) begin
      tick();
      k++;
    end
    check("push_ready_timeout", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < bound) begin
      tick();
      k++;
    end
    check("idle_timeout", busy || exp_q.size() != 0, 1'b0);
  endtask

  task automatic wait_sig(input string tag, input int which, input int bound);
    int k;
    logic s;
    k = 0;
    s = (which == 0) ? mem_key : cdb_valid;
    while (!s && k < bound) begin
      tick();
      k++;
      s = (which == 0) ? mem_key : cdb_valid;
    end
    check(tag, s, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed vectors ----------------
  initial begin
    int k0, b0, kv;
    logic [INSTR_W-1:0] x [6];
    logic [INSTR_W-1:0] nm;

    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    cdb_ack  = 1'b1;
    #2;
    check("rst_mem_key", mem_key, 0);
    check("rst_cdb_valid", cdb_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_instr", mem_instr, 0);
    check("rst_cdb_fields", {cdb_store, cdb_reg, cdb_tag, cdb_data}, 0);
    check("rst_state", state_dbg, 0);
`ifdef MEM_TIMEOUT_EN
    check("rst_timeout_err", timeout_err, 0);
`endif
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    check("rel_in_ready", in_ready, 1);

    // Store 0xBEEF to 0x0010, tag 2, reg 5
    k0 = key_cnt; b0 = bc_cnt;
    exp_q.push_back(bc(1'b1, 4'd5, 3'd2, 16'hBEEF));
    push(mk(3'd2, 1'b1, 4'd5, 16'h0010, 16'hBEEF));
    wait_idle(100);
    check("store_keys", key_cnt - k0, 1);
    check("store_bcasts", bc_cnt - b0, 1);

    // Load from 0x0010, tag 3, reg 7
    k0 = key_cnt; b0 = bc_cnt;
    exp_q.push_back(bc(1'b0, 4'd7, 3'd3, 16'hBEEF));
    push(mk(3'd3, 1'b0, 4'd7, 16'h0000, 16'h0010));
    wait_idle(100);
    check("load_keys", key_cnt - k0, 1);
    check("load_bcasts", bc_cnt - b0, 1);

    // Bus stalled: first instruction parks in WRITEBACK, 4 more fill FIFO
    k0 = key_cnt; b0 = bc_cnt;
    for (int i = 0; i < 6; i++) begin
      x[i] = mk(3'(i), 1'b1, 4'(8 + i), 16'h0020 + 16'(i), 16'hA000 + 16'(i));
      exp_q.push_back(bc(1'b1, 4'(8 + i), 3'(i), 16'hA000 + 16'(i)));
    end
    cdb_ack = 1'b0;
    push(x[0]);
    wait_sig("stall_valid_timeout", 1, 50);
    kv = key_cnt;
    for (int i = 1; i < 5; i++) push(x[i]);
    check("full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_instr = x[5];
    repeat (6) tick();
    check("full_hold_ready", in_ready, 0);
    check("stall_no_key", key_cnt - kv, 0);
    check("stall_valid", cdb_valid, 1);
    check("stall_no_bcast", bc_cnt - b0, 0);
    check("stall_fields", {cdb_store, cdb_reg, cdb_tag, cdb_data}, bc(1'b1, 4'd8, 3'd0, 16'hA000));
    check("stall_busy", busy, 1);
    cdb_ack = 1'b1;
    push(x[5]);
    wait_idle(300);
    check("stall_bcasts", bc_cnt - b0, 6);
    check("stall_keys", key_cnt - k0, 6);

    // Non-memory instruction is dropped
    k0 = key_cnt; b0 = bc_cnt;
    nm = mk(3'd1, 1'b1, 4'd3, 16'h0030, 16'h1234);
    nm[39] = 1'b0;
    push(nm);
    for (int i = 0; i < 5; i++) begin
      check("nonmem_busy", busy, 0);
      tick();
    end
    check("nonmem_keys", key_cnt - k0, 0);
    check("nonmem_bcasts", bc_cnt - b0, 0);

    // Reset while waiting on memory; late mem_done must be ignored
    k0 = key_cnt; b0 = bc_cnt;
    push(mk(3'd6, 1'b1, 4'd9, 16'h0040, 16'h5555));
    wait_sig("midrst_key_timeout", 0, 50);
    tick();
    reset_n = 1'b0;
    #1;
    check("midrst_state", state_dbg, 0);
    check("midrst_mem_instr", mem_instr, 0);
    check("midrst_cdb_fields", {cdb_store, cdb_reg, cdb_tag, cdb_data}, 0);
    check("midrst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    check("midrst_no_bcast", bc_cnt - b0, 0);
    check("midrst_idle", state_dbg, 0);
    check("midrst_busy_after", busy, 0);
    check("midrst_in_ready", in_ready, 1);

    // Normal operation resumes after reset
    exp_q.push_back(bc(1'b0, 4'd2, 3'd1, 16'hBEEF));
    push(mk(3'd1, 1'b0, 4'd2, 16'h0000, 16'h0010));
    wait_idle(100);

`ifdef MEM_TIMEOUT_EN
    begin
      int t [3];
      int n, cyc;
      logic [INSTR_W-1:0] ti;
      check("to_err_before", timeout_err, 0);
      mem_mute = 1'b1;
      ti = mk(3'd5, 1'b0, 4'd11, 16'h0000, 16'h0010);
      push(ti);
      n = 0; cyc = 0;
      while (n < 3 && cyc < 100) begin
        if (mem_key) begin
          t[n] = cyc;
          n++;
        end
        tick();
        cyc++;
      end
      check("to_pulses", n, 3);
      check("to_period1", t[1] - t[0], TO + 1);
      check("to_period2", t[2] - t[1], TO + 1);
      check("to_mem_instr", mem_instr, ti);
      check("to_err_set", timeout_err, 1);
      check("to_no_valid", cdb_valid, 0);
      reset_n = 1'b0;
      #1;
      check("to_rst_key", mem_key, 0);
      check("to_rst_valid", cdb_valid, 0);
      check("to_rst_busy", busy, 0);
      check("to_rst_instr", mem_instr, 0);
      check("to_rst_err", timeout_err, 0);
      check("to_rst_fields", {cdb_store, cdb_reg, cdb_tag, cdb_data}, 0);
      tick();
      reset_n = 1'b1;
      mem_mute = 1'b0;
      tick();
      check("to_rel_ready", in_ready, 1);
      check("to_rel_state", state_dbg, 0);
    end
`endif

    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
